// File: rtl/counter_arb.sv
// Round-robin arbiter granting a shared counter to NREQ requesters.
// Define COUNTER_ARB_TIMEOUT_EN to build the RUN-cycle watchdog.
module counter_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] start_value,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       aborted,
  output logic                  busy,
  output logic                  err,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_load_value,
  output logic                  cnt_enable,
  input  logic                  cnt_overflow
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, DONE
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [IW-1:0]   rr_ptr, rr_nx;
  logic [IW-1:0]   win, nxt_idx;
  logic [WIDTH-1:0] val, val_nx;
  logic [NREQ-1:0] abt, abt_nx;
  logic            err_q, err_nx;
  logic            found;
  logic            wd_hit;

  function automatic logic [IW-1:0] slot(
    input logic [IW-1:0] p,
    input int            k
  );
    int j;
    j = int'(p) + k;
    if (j >= NREQ) j -= NREQ;
    return IW'(j);
  endfunction

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[slot(rr_ptr, k)]) begin
        win   = slot(rr_ptr, k);
        found = 1'b1;
      end
    end
  end

  assign nxt_idx = (int'(idx) == NREQ - 1) ? '0 : idx + IW'(1);

`ifdef COUNTER_ARB_TIMEOUT_EN
  localparam int WW = WIDTH + 2;
  localparam logic [WW-1:0] WD_LAST = WW'(2 ** WIDTH + 3);

  logic [WW-1:0] wd, wd_nx;

  always_comb begin
    wd_nx = '0;
    if (state == RUN) wd_nx = wd + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wd <= '0;
    else     wd <= wd_nx;
  end

  // wd holds the number of RUN cycles already completed
  assign wd_hit = (state == RUN) && (wd == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    val_nx   = val;
    rr_nx    = rr_ptr;
    abt_nx   = '0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nx   = win;
          val_nx   = start_value[int'(win)*WIDTH +: WIDTH];
          state_nx = LOAD;
        end
      end
      LOAD, RUN: begin
        if (!req[idx]) begin
          state_nx    = IDLE;
          abt_nx[idx] = 1'b1;
          rr_nx       = nxt_idx;
        end else if (state == LOAD) begin
          state_nx = RUN;
        end else if (cnt_overflow) begin
          state_nx = DONE;
        end else if (wd_hit) begin
          state_nx    = IDLE;
          abt_nx[idx] = 1'b1;
          err_nx      = 1'b1;
          rr_nx       = nxt_idx;
        end
      end
      DONE: begin
        state_nx = IDLE;
        rr_nx    = nxt_idx;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      val    <= '0;
      rr_ptr <= '0;
      abt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      val    <= val_nx;
      rr_ptr <= rr_nx;
      abt    <= abt_nx;
      err_q  <= err_nx;
    end
  end

  assign gnt = (state == LOAD || state == RUN) ? (NREQ'(1) << idx) : '0;
  assign done = (state == DONE) ? (NREQ'(1) << idx) : '0;
  assign aborted = abt;
  assign err = err_q;
  assign busy = (state != IDLE);
  assign cnt_load = (state == LOAD);
  assign cnt_enable = (state == RUN);
  assign cnt_load_value = val;

endmodule

// File: tb/tb_counter_arb.sv
// Randomized bench for counter_arb against an owner/age reference model.
// Directed sequences first, then random traffic with resets and drops.
module tb_counter_arb;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] sv;
  logic           ovf;
  logic [N-1:0]   gnt, done, aborted;
  logic           busy, err, cnt_load, cnt_enable;
  logic [W-1:0]   cnt_load_value;

  always #5 clk = ~clk;

  counter_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .start_value(sv),
    .gnt(gnt), .done(done), .aborted(aborted), .busy(busy),
    .err(err), .cnt_load(cnt_load),
    .cnt_load_value(cnt_load_value),
    .cnt_enable(cnt_enable), .cnt_overflow(ovf)
  );

  int total = 0;
  int bad = 0;

  // model: m_own = owner in LOAD/RUN, m_age = RUN cycles seen,
  // m_fin = owner finishing, m_abt = aborted pulse index
  int         m_own, m_fin, m_age, m_abt, m_ptr;
  bit         m_err;
  logic [W-1:0] m_val;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    m_abt = -1;
    m_err = 1'b0;
    if (rst) begin
      m_own = -1; m_fin = -1; m_age = 0; m_ptr = 0; m_val = '0;
    end else if (m_fin >= 0) begin
      m_ptr = (m_fin + 1) % N;
      m_fin = -1;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_abt = m_own; m_ptr = (m_own + 1) % N; m_own = -1;
      end else if (m_age > 0 && ovf) begin
        m_fin = m_own; m_own = -1;
`ifdef COUNTER_ARB_TIMEOUT_EN
      end else if (m_age == (1 << W) + 4) begin
        m_abt = m_own; m_err = 1'b1;
        m_ptr = (m_own + 1) % N; m_own = -1;
`endif
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (req[j]) begin
          m_own = j; m_age = 0; m_val = sv[j*W +: W];
          break;
        end
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] eg, ed, ea;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_own >= 0) ? N'(1) << m_own : '0;
    ed = (m_fin >= 0) ? N'(1) << m_fin : '0;
    ea = (m_abt >= 0) ? N'(1) << m_abt : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("aborted", 32'(aborted), 32'(ea));
    chk("busy", 32'(busy), 32'(m_own >= 0 || m_fin >= 0));
    chk("err", 32'(err), 32'(m_err));
    chk("cnt_load", 32'(cnt_load), 32'(m_own >= 0 && m_age == 0));
    chk("cnt_enable", 32'(cnt_enable), 32'(m_own >= 0 && m_age > 0));
    chk("cnt_load_value", 32'(cnt_load_value), 32'(m_val));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ovf = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int dn, seen;
  logic [N-1:0] order[$];
  logic [N-1:0] first_gnt;

  initial begin
    rst = 1'b1; req = '0; sv = '0; ovf = 1'b0;
    m_own = -1; m_fin = -1; m_age = 0; m_abt = -1; m_ptr = 0;
    m_err = 1'b0; m_val = '0;
    tick();
    tick();
    rst = 1'b0;

    // start 250, overflow after 6 RUN cycles
    req = 2'b01; sv = {8'd0, 8'd250}; dn = 0;
    for (int c = 0; c < 12; c++) begin
      ovf = (m_own == 0 && m_age == 6);
      tick();
      if (c == 0) begin
        chk("a_load", 32'(cnt_load), 32'd1);
        chk("a_value", 32'(cnt_load_value), 32'd250);
      end
      if (done[0]) begin dn++; req = '0; end
    end
    chk("a_done_once", dn, 1);
    chk("a_idle", 32'(busy), 32'd0);

    // both requesting: strict alternation
    do_reset();
    req = 2'b11; sv = {8'd7, 8'd255}; dn = 0; order.delete();
    for (int c = 0; c < 200 && dn < 4; c++) begin
      ovf = (m_own >= 0 && m_age == 3);
      tick();
      if (cnt_load) order.push_back(gnt);
      if (done != '0) begin
        dn++;
        chk("b_done_match", 32'(done), 32'(order[order.size()-1]));
      end
    end
    chk("b_runs", dn, 4);
    for (int i = 0; i < 4; i++)
      chk("b_order", (i < order.size()) ? 32'(order[i]) : 32'hx,
          (i % 2 == 0) ? 32'd1 : 32'd2);

    // requester 1 drops on its 3rd RUN cycle
    do_reset();
    req = 2'b10; ovf = 1'b0; dn = 0; seen = 0; first_gnt = '0;
    for (int c = 0; c < 20; c++) begin
      if (m_own == 1 && m_age == 3) req = 2'b01;
      tick();
      if (aborted[1]) seen++;
      if (done != '0) dn++;
      if (req == 2'b01 && cnt_load && first_gnt == '0) first_gnt = gnt;
    end
    chk("c_aborted", seen, 1);
    chk("c_no_done", dn, 0);
    chk("c_next_gnt", 32'(first_gnt), 32'd1);

    // drop and overflow together: abort wins
    do_reset();
    req = 2'b01; seen = 0;
    for (int c = 0; c < 12; c++) begin
      ovf = 1'b0;
      if (m_own == 0 && m_age == 4) begin req = '0; ovf = 1'b1; end
      tick();
      if (aborted[0]) begin
        seen++;
        chk("d_no_done", 32'(done), 32'd0);
      end
    end
    chk("d_aborted", seen, 1);

    // reset mid-RUN must clear the round-robin pointer
    do_reset();
    req = 2'b01; ovf = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ovf = (m_own == 0 && m_age == 2);
      tick();
      if (done[0]) req = '0;
    end
    req = 2'b11; ovf = 1'b0;
    for (int c = 0; c < 10 && !(m_own == 1 && m_age == 2); c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("e_busy", 32'(busy), 32'd0);
    tick();
    chk("e_gnt_after", 32'(gnt), 32'd1);

    // long run without overflow: watchdog or keep running
    do_reset();
    req = 2'b10; ovf = 1'b0; seen = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (err) seen++;
    end
`ifdef COUNTER_ARB_TIMEOUT_EN
    chk("g_err", seen, 1);
`else
    chk("g_err", seen, 0);
    chk("g_running", 32'(cnt_enable), 32'd1);
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 3) == 0) sv = N*W'($urandom);
      ovf = ($urandom_range(0, 99) < 15);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_arb.md
COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the counter data path.
REQ-002 SHALL have parameter NREQ, default 2 (legal range 2..8): number of requesters.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, NREQ: per-requester run request, level, held until done or abort.
REQ-006 SHALL have port start_value, input, NREQ*WIDTH: per-requester load value; slice i belongs to requester i.
REQ-007 SHALL have port gnt, output, NREQ: one-hot owner of the counter; zero when no owner.
REQ-008 SHALL have port done, output, NREQ: one-cycle pulse when the owner's run completes on overflow.
REQ-009 SHALL have port aborted, output, NREQ: one-cycle pulse when the owner drops req mid-run.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port err, output, 1: one-cycle timeout pulse (see Configuration).
REQ-012 SHALL have port cnt_load, output, 1: load strobe to the shared counter.
REQ-013 SHALL have port cnt_load_value, output, WIDTH: value to load into the shared counter.
REQ-014 SHALL have port cnt_enable, output, 1: count enable to the shared counter.
REQ-015 SHALL have port cnt_overflow, input, 1: overflow pulse from the shared counter.

Function
REQ-016 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-017 SHALL, in IDLE with any req high, pick a winner by round-robin, latch its index and start_value, and enter LOAD next cycle.
REQ-018 SHALL start the round-robin search at the pointer rr_ptr, ascending with wrap (rr_ptr, rr_ptr+1, ... NREQ-1, 0, ...).
REQ-019 SHALL set gnt[idx] in LOAD and RUN only.
REQ-020 SHALL, in LOAD, drive cnt_load=1, cnt_enable=0 and cnt_load_value=latched value for exactly one cycle, then go to RUN.
REQ-021 SHALL hold cnt_load_value at the latched value in all states; the latch only updates on a grant.
REQ-022 SHALL, in RUN, drive cnt_enable=1 and cnt_load=0.
REQ-023 SHALL, in RUN, go to DONE on the cycle after cnt_overflow is sampled high.
REQ-024 SHALL, in DONE, drive done[idx]=1, gnt=0 and cnt_enable=0 for one cycle, set rr_ptr=(idx+1) mod NREQ, and return to IDLE.
REQ-025 SHALL treat req[idx] low in LOAD or RUN as an abort: go to IDLE next cycle, pulse aborted[idx], drive cnt_enable=0, set rr_ptr=(idx+1) mod NREQ, and not pulse done.
REQ-026 SHALL give abort priority over overflow when both are sampled in the same RUN cycle.
REQ-027 SHALL ignore cnt_overflow outside RUN.
REQ-028 SHALL ignore req changes of non-owners while busy.
REQ-029 SHALL take at least one IDLE cycle between grants.
REQ-030 SHALL, when start_value is all-ones, complete normally on the overflow after the first enabled cycle.

Reset
REQ-031 SHALL, while rst is high at a clock edge, enter IDLE and clear rr_ptr, the latched index and the latched value to 0.
REQ-032 SHALL drive the reset values of all outputs next cycle: gnt, done, aborted, busy, err, cnt_load and cnt_enable all 0; cnt_load_value 0.
REQ-033 SHALL, on reset in LOAD or RUN, drop the run silently, with no done, aborted or err pulse.

Configuration
REQ-034 SHALL, with macro COUNTER_ARB_TIMEOUT_EN defined, run a RUN-cycle watchdog that goes to IDLE after 2^WIDTH+4 RUN cycles without overflow, pulsing err and aborted[idx] and advancing rr_ptr as on abort.
REQ-035 SHALL, with COUNTER_ARB_TIMEOUT_EN undefined, contain no watchdog logic and tie err to 0; the port list is identical in both builds.

Verification
REQ-036 SHALL cover (WIDTH=8, NREQ=2, bench models cnt_overflow): req[0]=1, start_value[0]=250 -> next cycle LOAD with cnt_load=1 and cnt_load_value=250; overflow driven after 6 RUN cycles -> done[0] pulses exactly once, then busy=0.
REQ-037 SHALL cover: req=2'b11 held from reset -> grant order 0,1,0,1 over four runs, with a done pulse matching each gnt.
REQ-038 SHALL cover: req[1] dropped on the 3rd RUN cycle -> aborted[1] pulses next cycle, cnt_enable=0, no done, next grant goes to requester 0.
REQ-039 SHALL cover: req[0] drop and cnt_overflow in the same RUN cycle -> aborted[0]=1 and done[0]=0.
REQ-040 SHALL cover: rst=1 for one cycle during RUN -> all outputs 0 the next cycle, no pulses, rr_ptr=0.
REQ-041 SHALL cover: with COUNTER_ARB_TIMEOUT_EN defined and no overflow -> err and aborted[idx] pulse after 260 RUN cycles; without the macro -> err stays 0 and the run continues.
